// File: rtl/apb_req_master.sv
// Initiator-side APB4 bridge: turns a req/gnt/rvalid core data port into
// APB SETUP/ACCESS transfers, with a wait-state timeout against hung slaves.
module apb_req_master #(
   parameter int APB_ADDR_WIDTH = 32,
   parameter int APB_DATA_WIDTH = 32,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                        clk_i,
   input  logic                        rst_ni,
   input  logic                        req_i,
   output logic                        gnt_o,
   input  logic [APB_ADDR_WIDTH-1:0]   addr_i,
   input  logic                        we_i,
   input  logic [APB_DATA_WIDTH/8-1:0] be_i,
   input  logic [APB_DATA_WIDTH-1:0]   wdata_i,
   output logic                        rvalid_o,
   output logic [APB_DATA_WIDTH-1:0]   rdata_o,
   output logic                        err_o,
   output logic [APB_ADDR_WIDTH-1:0]   paddr_o,
   output logic [APB_DATA_WIDTH-1:0]   pwdata_o,
   output logic                        pwrite_o,
   output logic [APB_DATA_WIDTH/8-1:0] pstrb_o,
   output logic                        psel_o,
   output logic                        penable_o,
   input  logic [APB_DATA_WIDTH-1:0]   prdata_i,
   input  logic                        pready_i,
   input  logic                        pslverr_i
);

   localparam int STRB_W = APB_DATA_WIDTH / 8;
   localparam int CNT_W  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2
   } state_t;

   state_t                    r_state;
   logic [APB_ADDR_WIDTH-1:0] r_paddr;
   logic [APB_DATA_WIDTH-1:0] r_pwdata;
   logic                      r_pwrite;
   logic [STRB_W-1:0]         r_pstrb;
   logic                      r_psel;
   logic                      r_penable;
   logic                      r_rvalid;
   logic [APB_DATA_WIDTH-1:0] r_rdata;
   logic                      r_err;
   logic [CNT_W-1:0]          r_cnt;

   logic [CNT_W-1:0]          w_cnt_inc;
   logic                      w_timeout;

   // Saturating wait-state count including the current cycle.
   assign w_cnt_inc = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CNT_W'(1);
   assign w_timeout = (TIMEOUT_CYCLES != 0) && (w_cnt_inc == CNT_LAST);

   assign gnt_o     = rst_ni && (r_state == IDLE) && req_i;
   assign paddr_o   = r_paddr;
   assign pwdata_o  = r_pwdata;
   assign pwrite_o  = r_pwrite;
   assign pstrb_o   = r_pstrb;
   assign psel_o    = r_psel;
   assign penable_o = r_penable;
   assign rvalid_o  = r_rvalid;
   assign rdata_o   = r_rdata;
   assign err_o     = r_err;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state   <= IDLE;
         r_paddr   <= '0;
         r_pwdata  <= '0;
         r_pwrite  <= 1'b0;
         r_pstrb   <= '0;
         r_psel    <= 1'b0;
         r_penable <= 1'b0;
         r_rvalid  <= 1'b0;
         r_rdata   <= '0;
         r_err     <= 1'b0;
         r_cnt     <= '0;
      end else begin
         r_rvalid <= 1'b0;
         case (r_state)
            IDLE: begin
               if (req_i) begin
                  r_paddr  <= addr_i;
                  r_pwrite <= we_i;
                  r_pwdata <= wdata_i;
                  r_pstrb  <= we_i ? be_i : '0;
                  r_psel   <= 1'b1;
                  r_state  <= SETUP;
               end
            end
            SETUP: begin
               r_penable <= 1'b1;
               r_state   <= ACCESS;
            end
            ACCESS: begin
               if (pready_i) begin
                  r_psel    <= 1'b0;
                  r_penable <= 1'b0;
                  r_rvalid  <= 1'b1;
                  r_rdata   <= r_pwrite ? '0 : prdata_i;
                  r_err     <= pslverr_i;
                  r_cnt     <= '0;
                  r_state   <= IDLE;
               end else if (w_timeout) begin
                  r_psel    <= 1'b0;
                  r_penable <= 1'b0;
                  r_rvalid  <= 1'b1;
                  r_rdata   <= '0;
                  r_err     <= 1'b1;
                  r_cnt     <= '0;
                  r_state   <= IDLE;
               end else begin
                  r_cnt <= w_cnt_inc;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_apb_req_master.sv
// Directed bench for apb_req_master: zero-wait read, waited write, slave error,
// timeout, back-to-back transfers and reset during ACCESS.
module tb_apb_req_master;

   logic        clk_i = 1'b0;
   logic        rst_ni;
   logic        req_i;
   logic        gnt_o;
   logic [31:0] addr_i;
   logic        we_i;
   logic [3:0]  be_i;
   logic [31:0] wdata_i;
   logic        rvalid_o;
   logic [31:0] rdata_o;
   logic        err_o;
   logic [31:0] paddr_o;
   logic [31:0] pwdata_o;
   logic        pwrite_o;
   logic [3:0]  pstrb_o;
   logic        psel_o;
   logic        penable_o;
   logic [31:0] prdata_i;
   logic        pready_i;
   logic        pslverr_i;

   int total = 0;
   int bad   = 0;

   apb_req_master #(
      .APB_ADDR_WIDTH(32),
      .APB_DATA_WIDTH(32),
      .TIMEOUT_CYCLES(4)
   ) dut (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .req_i(req_i), .gnt_o(gnt_o), .addr_i(addr_i), .we_i(we_i),
      .be_i(be_i), .wdata_i(wdata_i),
      .rvalid_o(rvalid_o), .rdata_o(rdata_o), .err_o(err_o),
      .paddr_o(paddr_o), .pwdata_o(pwdata_o), .pwrite_o(pwrite_o),
      .pstrb_o(pstrb_o), .psel_o(psel_o), .penable_o(penable_o),
      .prdata_i(prdata_i), .pready_i(pready_i), .pslverr_i(pslverr_i)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Inputs change and outputs are sampled around the falling edge.
   task automatic next_cycle();
      @(negedge clk_i);
   endtask

   // Zero-wait read: c0 grant, c1 SETUP, c2 ACCESS with pready, c3 response.
   task automatic read0(input string tag, input logic [31:0] addr,
                        input logic [31:0] data, input logic slverr);
      next_cycle();
      req_i = 1'b1; addr_i = addr; we_i = 1'b0; be_i = 4'hF;
      wdata_i = 32'hFFFF_FFFF; pready_i = 1'b0;
      #1 chk({tag, "_gnt_c0"}, 32'(gnt_o), 32'd1);
      next_cycle();
      req_i = 1'b0; addr_i = 32'h0; pready_i = 1'b1; pslverr_i = 1'b1;
      prdata_i = 32'h0BAD_0BAD;
      #1 chk({tag, "_setup_c1"}, {30'd0, psel_o, penable_o}, 32'b10);
      chk({tag, "_paddr_c1"}, paddr_o, addr);
      chk({tag, "_pstrb_rd"}, {pwrite_o, 27'd0, pstrb_o}, 32'h0);
      next_cycle();
      prdata_i = data; pslverr_i = slverr;
      #1 chk({tag, "_access_c2"}, {29'd0, psel_o, penable_o, rvalid_o}, 32'b110);
      next_cycle();
      pready_i = 1'b0; pslverr_i = 1'b0; prdata_i = 32'h0;
      #1 chk({tag, "_rvalid_c3"}, {28'd0, rvalid_o, psel_o, penable_o, gnt_o}, 32'b1000);
      chk({tag, "_rdata"}, rdata_o, data);
      chk({tag, "_err"}, 32'(err_o), 32'(slverr));
      next_cycle();
      #1 chk({tag, "_rvalid_pulse"}, 32'(rvalid_o), 32'd0);
      chk({tag, "_rdata_hold"}, rdata_o, data);
   endtask

   initial begin
      rst_ni = 1'b0; req_i = 1'b0; addr_i = 32'h0; we_i = 1'b0; be_i = 4'h0;
      wdata_i = 32'h0; prdata_i = 32'h0; pready_i = 1'b0; pslverr_i = 1'b0;

      // Reset state, with a request pending to show gnt is held low.
      next_cycle();
      req_i = 1'b1;
      #1 chk("rst_ctrl", {27'd0, gnt_o, psel_o, penable_o, rvalid_o, err_o}, 32'h0);
      chk("rst_paddr", paddr_o, 32'h0);
      chk("rst_pwdata", pwdata_o, 32'h0);
      chk("rst_rdata", rdata_o, 32'h0);
      chk("rst_pw_strb", {pwrite_o, 27'd0, pstrb_o}, 32'h0);
      next_cycle();
      req_i = 1'b0;
      rst_ni = 1'b1;
      next_cycle();

      // 1: read, zero wait states.
      read0("t1", 32'h1A10_0008, 32'hDEAD_BEEF, 1'b0);

      // 2: write with 3 wait states; request inputs change after grant.
      next_cycle();
      req_i = 1'b1; addr_i = 32'h1A10_1000; we_i = 1'b1; be_i = 4'b0011;
      wdata_i = 32'h1234_5678; prdata_i = 32'hCAFE_F00D;
      #1 chk("t2_gnt_c0", 32'(gnt_o), 32'd1);
      next_cycle();
      req_i = 1'b0; addr_i = 32'h5555_5555; we_i = 1'b0; be_i = 4'hC;
      wdata_i = 32'h9999_9999;
      #1 chk("t2_setup_c1", {30'd0, psel_o, penable_o}, 32'b10);
      for (int c = 1; c <= 5; c++) begin
         if (c > 1) next_cycle();
         if (c == 5) pready_i = 1'b1;
         #1 chk($sformatf("t2_paddr_c%0d", c), paddr_o, 32'h1A10_1000);
         chk($sformatf("t2_pwdata_c%0d", c), pwdata_o, 32'h1234_5678);
         chk($sformatf("t2_pw_strb_c%0d", c), {pwrite_o, 27'd0, pstrb_o}, 32'h8000_0003);
         if (c > 1)
            chk($sformatf("t2_access_c%0d", c), {29'd0, psel_o, penable_o, rvalid_o}, 32'b110);
      end
      next_cycle();
      pready_i = 1'b0;
      #1 chk("t2_rvalid_c6", {29'd0, rvalid_o, psel_o, penable_o}, 32'b100);
      chk("t2_rdata_wr", rdata_o, 32'h0);
      chk("t2_err", 32'(err_o), 32'd0);

      // 3: slave error, then a clean read clears err.
      read0("t3a", 32'h1A10_2004, 32'h5555_AAAA, 1'b1);
      read0("t3b", 32'h1A10_2008, 32'h0BAD_F00D, 1'b0);

      // 4: timeout after 4 ACCESS cycles with pready low; late pready ignored.
      next_cycle();
      req_i = 1'b1; addr_i = 32'h1A10_3000; we_i = 1'b0; pready_i = 1'b0;
      prdata_i = 32'h7777_7777;
      #1 chk("t4_gnt_c0", 32'(gnt_o), 32'd1);
      next_cycle();
      req_i = 1'b0;
      #1 chk("t4_setup_c1", {30'd0, psel_o, penable_o}, 32'b10);
      for (int c = 2; c <= 5; c++) begin
         next_cycle();
         #1 chk($sformatf("t4_wait_c%0d", c), {29'd0, psel_o, penable_o, rvalid_o}, 32'b110);
      end
      next_cycle();
      pready_i = 1'b1;
      #1 chk("t4_abort_c6", {29'd0, rvalid_o, psel_o, penable_o}, 32'b100);
      chk("t4_err", 32'(err_o), 32'd1);
      chk("t4_rdata", rdata_o, 32'h0);
      next_cycle();
      #1 chk("t4_late_rdy_c7", {29'd0, rvalid_o, psel_o, penable_o}, 32'b000);
      chk("t4_err_hold", 32'(err_o), 32'd1);
      pready_i = 1'b0;

      // 5: back-to-back, req held high for three transfers, pready always 1.
      next_cycle();
      #1;
      pready_i = 1'b1;
      for (int k = 0; k <= 9; k++) begin
         next_cycle();
         if (k == 0) req_i = 1'b1;
         if (k == 7) req_i = 1'b0;
         if (k % 3 == 0) addr_i = 32'h1A10_4000 + 32'(k);
         prdata_i = 32'h1111_0000 | 32'(k);
         #1 chk($sformatf("t5_gnt_c%0d", k), 32'(gnt_o), 32'((k % 3 == 0) && (k < 9)));
         chk($sformatf("t5_psel_c%0d", k), 32'(psel_o), 32'(k % 3 != 0));
         chk($sformatf("t5_penable_c%0d", k), 32'(penable_o), 32'(k % 3 == 2));
         chk($sformatf("t5_rvalid_c%0d", k), 32'(rvalid_o), 32'((k % 3 == 0) && (k > 0)));
         if (k % 3 == 1) chk($sformatf("t5_paddr_c%0d", k), paddr_o, 32'h1A10_4000 + 32'(k - 1));
         if ((k % 3 == 0) && (k > 0))
            chk($sformatf("t5_rdata_c%0d", k), rdata_o, 32'h1111_0000 | 32'(k - 1));
      end
      pready_i = 1'b0;

      // 6: reset asserted during ACCESS, then a normal read.
      next_cycle();
      req_i = 1'b1; addr_i = 32'h1A10_5000; we_i = 1'b0;
      #1 chk("t6_gnt_c0", 32'(gnt_o), 32'd1);
      next_cycle();
      req_i = 1'b0;
      next_cycle();
      #1 chk("t6_access_c2", {30'd0, psel_o, penable_o}, 32'b11);
      #1 rst_ni = 1'b0;
      #1 chk("t6_async_drop", {30'd0, psel_o, penable_o}, 32'b00);
      req_i = 1'b1;
      next_cycle();
      #1 chk("t6_in_reset", {29'd0, gnt_o, rvalid_o, psel_o}, 32'b000);
      next_cycle();
      req_i = 1'b0;
      rst_ni = 1'b1;
      for (int c = 0; c < 3; c++) begin
         next_cycle();
         #1 chk($sformatf("t6_no_rvalid_%0d", c), {30'd0, rvalid_o, psel_o}, 32'b00);
      end
      chk("t6_rdata_cleared", rdata_o, 32'h0);
      read0("t6_read", 32'h1A10_0008, 32'hDEAD_BEEF, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
